// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC sequencer: widths, saturation value
// and the sequencer state encoding.
package neuron_pkg;

    localparam int NEURON_DATA_W = 8;
    localparam int NEURON_ADDR_W = 8;
    localparam int NEURON_ACC_W  = 24;
    localparam int NEURON_SHIFT  = 4;

    localparam logic [7:0] NEURON_SAT = 8'hFF;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH_X = 3'd1;
    localparam logic [2:0] ST_FETCH_W = 3'd2;
    localparam logic [2:0] ST_SCALE   = 3'd3;
    localparam logic [2:0] ST_WRITE   = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_FETCH_X = ST_FETCH_X,
        S_FETCH_W = ST_FETCH_W,
        S_SCALE   = ST_SCALE,
        S_WRITE   = ST_WRITE,
        S_DONE    = ST_DONE
    } state_t;

endpackage

// File: rtl/neuron_mac_sequencer_mac.sv
// Multiply-accumulate datapath: unsigned product into a clearable accumulator,
// followed by a right shift and saturation to the output width.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W = NEURON_DATA_W,
    parameter int ACC_W  = NEURON_ACC_W,
    parameter int SHIFT  = NEURON_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic [DATA_W-1:0] scaled
);

    logic [2*DATA_W-1:0] product;
    logic [ACC_W-1:0]    acc_reg;
    logic [ACC_W-1:0]    acc_next;
    logic [ACC_W-1:0]    shifted;
    logic                overflow;

    always_comb begin
        product  = x * w;
        acc_next = acc_reg + ACC_W'(product);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_next;
        end
    end

    // Any set bit above the output width means the scaled sum exceeds 255.
    always_comb begin
        shifted  = acc_reg >> SHIFT;
        overflow = |shifted[ACC_W-1:DATA_W];
        scaled   = overflow ? DATA_W'(NEURON_SAT) : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Neuron RAM master: fetches input/weight pairs through the read port,
// accumulates their products, then writes the scaled, saturated result.
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int DATA_W = NEURON_DATA_W,
    parameter int ADDR_W = NEURON_ADDR_W,
    parameter int ACC_W  = NEURON_ACC_W,
    parameter int SHIFT  = NEURON_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_inputs,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W-1:0] read_address,
    output logic              oe,
    input  logic [DATA_W-1:0] read_data,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    output logic              wre,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] n_reg, in_base_reg, w_base_reg, out_addr_reg, i_reg;
    logic [DATA_W-1:0] x_reg, result_reg, scaled;
    logic              start_ok;
    logic              last_pair;

    assign start_ok  = (state_reg == S_IDLE) && start;
    assign last_pair = (i_reg == n_reg - ADDR_W'(1));
    assign result    = result_reg;

    neuron_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SHIFT  (SHIFT)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_ok),
        .en     (state_reg == S_FETCH_W),
        .x      (x_reg),
        .w      (read_data),
        .scaled (scaled)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            n_reg        <= '0;
            in_base_reg  <= '0;
            w_base_reg   <= '0;
            out_addr_reg <= '0;
            i_reg        <= '0;
            x_reg        <= '0;
            result_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                n_reg        <= n_inputs;
                in_base_reg  <= in_base;
                w_base_reg   <= w_base;
                out_addr_reg <= out_addr;
                i_reg        <= '0;
            end
            if (state_reg == S_FETCH_X) begin
                x_reg <= read_data;
            end
            if (state_reg == S_FETCH_W && !last_pair) begin
                i_reg <= i_reg + ADDR_W'(1);
            end
            if (state_reg == S_SCALE) begin
                result_reg <= scaled;
            end
        end
    end

    // RAM port controls are decoded from state so reset removes them at once.
    always_comb begin
        state_next    = state_reg;
        busy          = 1'b1;
        oe            = 1'b0;
        read_address  = '0;
        wre           = 1'b0;
        write_address = '0;
        write_data    = '0;
        done          = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (n_inputs != '0) ? S_FETCH_X : S_SCALE;
                end
            end
            S_FETCH_X: begin
                oe           = 1'b1;
                read_address = in_base_reg + i_reg;
                state_next   = S_FETCH_W;
            end
            S_FETCH_W: begin
                oe           = 1'b1;
                read_address = w_base_reg + i_reg;
                state_next   = last_pair ? S_SCALE : S_FETCH_X;
            end
            S_SCALE: begin
                state_next = S_WRITE;
            end
            S_WRITE: begin
                wre           = 1'b1;
                write_address = out_addr_reg;
                write_data    = result_reg;
                state_next    = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with a transaction-level model of
// the RAM, the expected result and the per-cycle port schedule.
module tb_neuron_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] n_inputs, in_base, w_base, out_addr;
    logic [7:0] read_address, write_address, write_data, result;
    logic [7:0] read_data;
    logic       oe, wre, busy, done;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_mac_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .n_inputs      (n_inputs),
        .in_base       (in_base),
        .w_base        (w_base),
        .out_addr      (out_addr),
        .read_address  (read_address),
        .oe            (oe),
        .read_data     (read_data),
        .write_address (write_address),
        .write_data    (write_data),
        .wre           (wre),
        .busy          (busy),
        .done          (done),
        .result        (result)
    );

    assign read_data = oe ? mem[read_address] : 8'hzz;

    always @(posedge clk) begin
        if (wre) mem[write_address] <= write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_result(input int n, input logic [7:0] ib, input logic [7:0] wb);
        int unsigned sum = 0;
        int unsigned v;
        for (int j = 0; j < n; j++) begin
            sum += int'(mem[8'(ib + j)]) * int'(mem[8'(wb + j)]);
        end
        v = sum >> 4;
        return (v > 255) ? 8'd255 : v[7:0];
    endfunction

    // Model: model_k is the cycle number within the current transaction (0 = idle).
    int         model_k = 0;
    int         m_n = 0;
    logic [7:0] m_in, m_w, m_out, m_res;
    logic [7:0] last_res = 8'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_k  = 0;
            last_res = 8'd0;
        end else if (model_k == 0) begin
            if (start) begin
                m_n     = int'(n_inputs);
                m_in    = in_base;
                m_w     = w_base;
                m_out   = out_addr;
                m_res   = model_result(m_n, in_base, w_base);
                model_k = 1;
            end
        end else if (model_k == 2 * m_n + 3) begin
            model_k  = 0;
            last_res = m_res;
        end else begin
            model_k++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic       e_oe, e_wre;
            logic [7:0] e_ra;
            e_oe  = (model_k >= 1) && (model_k <= 2 * m_n);
            e_wre = (model_k != 0) && (model_k == 2 * m_n + 2);
            e_ra  = (model_k % 2 == 1) ? 8'(m_in + (model_k - 1) / 2) : 8'(m_w + model_k / 2 - 1);
            chk("busy", busy, model_k != 0);
            chk("oe", oe, e_oe);
            if (e_oe) chk("read_address", read_address, e_ra);
            chk("wre", wre, e_wre);
            if (e_wre) begin
                chk("write_address", write_address, m_out);
                chk("write_data", write_data, m_res);
            end
            chk("done", done, (model_k != 0) && (model_k == 2 * m_n + 3));
            chk("result", result, (model_k != 0 && model_k >= 2 * m_n + 2) ? m_res : last_res);
        end
    end

    task automatic run_op(input int n, input logic [7:0] ib, input logic [7:0] wb,
                          input logic [7:0] ob, input logic [7:0] exp_val,
                          input int exp_wre, input int exp_done, input bit pulse,
                          input string tag);
        int c      = 1;
        int wre_c  = 0;
        int done_c = 0;
        bit oe_seen = 1'b0;
        @(negedge clk);
        start = 1'b1; n_inputs = 8'(n); in_base = ib; w_base = wb; out_addr = ob;
        @(negedge clk);
        start = 1'b0;
        while (done_c == 0 && c < 200) begin
            if (oe) oe_seen = 1'b1;
            if (wre && wre_c == 0) wre_c = c;
            if (done) done_c = c;
            if (done_c == 0) begin
                if (pulse && (c == 3 || c == 2 * n + 2)) begin
                    start = 1'b1; out_addr = 8'd50; n_inputs = 8'd1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                c++;
            end
        end
        if (pulse) begin
            start = 1'b1; out_addr = 8'd50;
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_wre_cycle"}, wre_c, exp_wre);
        chk({tag, "_done_cycle"}, done_c, exp_done);
        chk({tag, "_ram_value"}, mem[ob], exp_val);
        chk({tag, "_result_port"}, result, exp_val);
        if (n == 0) chk({tag, "_oe_seen"}, oe_seen, 1'b0);
        $display("%s: n=%0d in=%0d w=%0d out=%0d wrote %0d (wre@%0d done@%0d)",
                 tag, n, ib, wb, ob, mem[ob], wre_c, done_c);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        n_inputs = '0; in_base = '0; w_base = '0; out_addr = '0;
        for (int a = 0; a < 256; a++) mem[a] = 8'd0;
        mem[0] = 8'd10; mem[1] = 8'd11; mem[2] = 8'd5; mem[3] = 8'd2;
        mem[4] = 8'd4;  mem[5] = 8'd5;  mem[6] = 8'd3; mem[7] = 8'd2;
        mem[40] = 8'd255; mem[41] = 8'd255;
        mem[255] = 8'd6; mem[100] = 8'd7; mem[101] = 8'd9;
        mem[20] = 8'h5A; mem[50] = 8'hC3; mem[60] = 8'h33;
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_oe", oe, 1'b0);
        chk("rst_wre", wre, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'd0);
        chk("rst_read_address", read_address, 8'd0);
        chk("rst_write_address", write_address, 8'd0);
        chk("rst_write_data", write_data, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(4, 8'd0, 8'd4, 8'd8, 8'd7, 10, 11, 1'b0, "nominal");

        // Abort in FETCH_W with i=2 (cycle 6); destination must stay untouched.
        @(negedge clk);
        start = 1'b1; n_inputs = 8'd4; in_base = 8'd0; w_base = 8'd4; out_addr = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_oe", oe, 1'b1);
        chk("abort_pre_addr", read_address, 8'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_oe", oe, 1'b0);
        chk("abort_wre", wre, 1'b0);
        chk("abort_read_address", read_address, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_ram_untouched", mem[20], 8'h5A);
        $display("abort: reset in FETCH_W, RAM[20]=%0d", mem[20]);

        mem[8] = 8'd0;
        run_op(4, 8'd0, 8'd4, 8'd8, 8'd7, 10, 11, 1'b0, "after_abort");
        run_op(2, 8'd40, 8'd40, 8'd42, 8'd255, 6, 7, 1'b0, "saturate");
        run_op(0, 8'd0, 8'd4, 8'd60, 8'd0, 2, 3, 1'b0, "n_zero");
        run_op(2, 8'd255, 8'd100, 8'd30, 8'd8, 6, 7, 1'b0, "wrap");
        run_op(4, 8'd0, 8'd4, 8'd70, 8'd7, 10, 11, 1'b1, "start_busy");

        repeat (10) @(negedge clk);
        chk("ignored_start_ram", mem[50], 8'hC3);
        chk("final_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Drives both ports of the neuron's dual-port weight/activation RAM. On `start`, it reads `n_inputs` input activations and `n_inputs` weights through the RAM read port and accumulates their products. It then scales and saturates the sum and writes the 8-bit neuron output back through the RAM write port. It is the master that sits between the layer controller and the neuron RAM.

## Interface
- `DATA_W`, 8: RAM data width; all operands are unsigned.
- `ADDR_W`, 8: RAM address width; all address arithmetic is modulo 2^ADDR_W.
- `ACC_W`, 24: accumulator width; no overflow for up to 255 terms of 255×255.
- `SHIFT`, 4: right shift applied to the accumulator before saturation.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `n_inputs`  in  ADDR_W  number of input/weight pairs; captured on accepted `start`.
- `in_base`  in  ADDR_W  address of input 0; captured on `start`.
- `w_base`  in  ADDR_W  address of weight 0; captured on `start`.
- `out_addr`  in  ADDR_W  destination address of the result; captured on `start`.
- `read_address`  out  ADDR_W  to RAM read port.
- `oe`  out  1  RAM read enable.
- `read_data`  in  DATA_W  from RAM; combinational, same-cycle.
- `write_address`  out  ADDR_W  to RAM write port.
- `write_data`  out  DATA_W  to RAM write port.
- `wre`  out  1  RAM write enable; the RAM commits on the next rising edge.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the write commits.
- `result`  out  DATA_W  last written value; held until the next write.

## Operation
- FSM states: IDLE, FETCH_X, FETCH_W, SCALE, WRITE, DONE.
- **IDLE**
  - On `start`, capture the operands, clear `acc` and index `i`.
  - Go to FETCH_X if `n_inputs` != 0, else go to SCALE.
- **FETCH_X**
  - Drive `oe`=1 and `read_address`=`in_base`+`i`.
  - Register `x`=`read_data`, then go to FETCH_W.
- **FETCH_W**
  - Drive `oe`=1 and `read_address`=`w_base`+`i`.
  - Update `acc` += `x`×`read_data`, zero-extended to ACC_W.
  - If `i`==`n_inputs`−1, go to SCALE; else increment `i` and go to FETCH_X.
- **SCALE**
  - `result` = (`acc`>>SHIFT) > 255 ? 255 : (`acc`>>SHIFT)[7:0].
  - Go to WRITE.
- **WRITE**
  - Drive `wre`=1, `write_address`=`out_addr`, `write_data`=`result`, `oe`=0.
  - Go to DONE.
- **DONE**
  - Drive `done`=1, then go to IDLE.
- `oe` is 0 outside FETCH_X/FETCH_W; `read_data` is don't-care (may be Z) when `oe`=0.
- No read is issued in the same cycle as a write, so the RAM write-bypass path is never exercised.
- `start` while `busy` is ignored, with no queuing.
- Address wrap: `in_base`+`i` and `w_base`+`i` wrap modulo 256.
- Overlapping input, weight and output regions are legal. The output write happens after all reads.

## Timing
- Reset (async, immediate):
  - State returns to IDLE.
  - `oe`, `wre`, `busy`, `done` = 0.
  - `read_address`, `write_address`, `write_data`, `result`, `acc`, `i` = 0.
- Reset asserted mid-operation aborts with no write. If asserted during WRITE, `wre` drops immediately and the RAM commit is not guaranteed.
- Latency, with `start` sampled at edge 0:
  - FETCH cycles occupy edges 1..2N.
  - SCALE at 2N+1, WRITE (`wre` high) at 2N+2, `done` high during cycle 2N+3.
  - Total 2N+3 cycles; for N=0 it is 3 cycles.
- Throughput: one product per 2 cycles, limited by the single read port.
- `busy` rises the cycle after the accepted `start` and falls when returning to IDLE. `start` is accepted again in the cycle after DONE.

## Structure
- Shared package `neuron_pkg`:
  - State encoding localparams.
  - DATA_W/ADDR_W/ACC_W defaults.
  - Saturation constant 8'hFF.
- One sub-module, `neuron_mac`:
  - Registered `acc` with clear and enable.
  - Unsigned DATA_W×DATA_W multiply.
  - Shift/saturate output.
  - The FSM and address generation stay in `neuron_mac_sequencer`.

## Test plan
- **Nominal:** RAM[0..3]=10,11,5,2 and RAM[4..7]=4,5,3,2. Start with N=4, in_base=0, w_base=4, out_addr=8. Sum is 114; expect 114>>4=7 written to RAM[8], `wre` at cycle 10, `done` at cycle 11.
- **Saturation:** N=2, all operands 255. acc=130050, >>4=8128; expect 255 written.
- **N=0:** expect 0 written to `out_addr` with `wre` at cycle 2, `done` at cycle 3, and `oe` never asserted.
- **Wrap-around:** in_base=255, N=2. Expect reads at 255 then 0, and the correct product sum.
- **Reset mid-FETCH_W** (i=2 of 4):
  - `busy`/`oe` drop asynchronously and no `wre` occurs.
  - A subsequent start of the nominal case still writes 7.
- **`start` pulsed while busy:** it is ignored, and exactly one `done` occurs per accepted start.
